clk_wiz: RTL and testbench
==========================

CLK_WIZ -- requirements
Module: clk_wiz

Interface
REQ-001 Parameter DIV, default 2, output clock period in w_clk cycles; even, >= 2.
REQ-002 Parameter LOCK_CYCLES, default 16, w_clk2 rising events after reset before lock; >= 1.
REQ-003 Parameter PW, default 32, probe width.
REQ-004 w_clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-005 w_rst  input  1  asynchronous, active-high reset.
REQ-006 w_clk2  output  1  divided clock, registered.
REQ-007 w_locked  output  1  output clock stable indicator.
REQ-008 w_probe_in  input  PW  debug probe value, e.g. the processor's r_rout.
REQ-009 w_chg_clr  input  1  clears the sticky change flag.
REQ-010 w_probe_q  output  PW  last captured probe value.
REQ-011 w_probe_chg  output  1  sticky flag, set when a capture differs from the previous capture.
REQ-012 w_sample_cnt  output  16  number of captures since reset, saturating.

Function
REQ-013 Divider counter div_cnt SHALL count 0..DIV-1 and wrap to 0, advancing on every w_clk edge.
REQ-014 On each edge, w_clk2 SHALL be loaded with (next div_cnt < DIV/2), giving a 50% duty cycle and period DIV.
REQ-015 A capture strobe SHALL be defined on the w_clk edge where div_cnt wraps from DIV-1 to 0; this is the same edge on which w_clk2 rises.
REQ-016 lock_cnt SHALL increment on each strobe and saturate at LOCK_CYCLES.
REQ-017 w_locked SHALL be registered and go high on the edge where lock_cnt reaches LOCK_CYCLES.
REQ-018 w_locked SHALL stay high until reset.
REQ-019 On a strobe while w_locked is already high, w_probe_q SHALL load w_probe_in.
REQ-020 On that same strobe, w_sample_cnt SHALL increment, saturating at 16'hFFFF.
REQ-021 On a strobe while w_locked is low, no capture SHALL occur and w_sample_cnt SHALL NOT change.
REQ-022 On a capture where w_probe_in differs from the current w_probe_q, w_probe_chg SHALL be set.
REQ-023 w_chg_clr high SHALL clear w_probe_chg on the next edge.
REQ-024 If a set and a clear occur on the same edge, the set SHALL win.
REQ-025 w_probe_in SHALL be sampled only on strobe edges; changes between strobes SHALL have no effect.
REQ-026 All outputs SHALL come directly from registers, with no combinational paths from inputs to outputs.

Reset
REQ-027 w_rst high SHALL immediately force the following, regardless of w_clk:
- div_cnt=0, lock_cnt=0
- w_clk2=0, w_locked=0
- w_probe_q=0, w_probe_chg=0, w_sample_cnt=0
REQ-028 Reset asserted mid-operation SHALL abort any pending capture and drop w_locked asynchronously.
REQ-029 The lock sequence SHALL restart from zero after w_rst is released.
REQ-030 The first w_clk edge after w_rst is released SHALL advance div_cnt to 1.

Structure
REQ-031 A shared package SHALL hold the DIV, LOCK_CYCLES and PW defaults and the 16-bit sample-count width constant.
REQ-032 A single sub-module, clk_div_lock (divider plus lock counter, exporting the strobe and w_locked), SHALL be used.
REQ-033 Probe capture logic SHALL live in the top module.

Verification
REQ-034 DIV=2, release reset -> w_clk2 = 0,1,0,1 on successive edges, first rising edge on the 2nd w_clk edge after release.
REQ-035 DIV=4, LOCK_CYCLES=3 -> w_clk2 high for 2 edges and low for 2, w_locked rises on the 12th edge after release.
REQ-036 DIV=2, LOCK_CYCLES=16 -> w_locked rises on the 32nd edge after release.
REQ-037 Locked, w_probe_in=32'h0000_00AA held, then 32'h0000_0055 -> w_probe_q follows at strobe edges only, w_probe_chg=1, w_sample_cnt increments once per strobe.
REQ-038 Locked, w_chg_clr=1 on the same edge as a differing capture -> w_probe_chg stays 1; w_chg_clr=1 with no capture -> w_probe_chg = 0 next edge.
REQ-039 Assert w_rst mid-run with w_sample_cnt=5 and w_locked=1 -> all outputs 0 immediately without a clock edge, and relock takes the full LOCK_CYCLES strobes.

Source files
------------

// File: rtl/clk_wiz_pkg.sv
// clk_wiz_pkg: shared defaults and helpers for the clock wizard and its probe capture.
package clk_wiz_pkg;
    localparam int DIV_DEF  = 2;
    localparam int LOCK_DEF = 16;
    localparam int PW_DEF   = 32;
    localparam int SCW      = 16;

    function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/clk_wiz_if.sv
// clk_wiz_if: divided clock, lock status and probe capture signals of clk_wiz.
interface clk_wiz_if
    import clk_wiz_pkg::*;
#(
    parameter int PW = PW_DEF
);
    logic           w_clk2;
    logic           w_locked;
    logic [PW-1:0]  w_probe_in;
    logic           w_chg_clr;
    logic [PW-1:0]  w_probe_q;
    logic           w_probe_chg;
    logic [SCW-1:0] w_sample_cnt;

    modport master (
        output w_probe_in, w_chg_clr,
        input  w_clk2, w_locked, w_probe_q, w_probe_chg, w_sample_cnt
    );
    modport slave (
        input  w_probe_in, w_chg_clr,
        output w_clk2, w_locked, w_probe_q, w_probe_chg, w_sample_cnt
    );
endinterface

// File: rtl/clk_wiz_div_lock.sv
// clk_div_lock: 50% duty divider plus lock counter; strobe marks the edge where w_clk2 rises.
module clk_div_lock #(
    parameter int DIV         = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic w_clk,
    input  logic w_rst,
    output logic w_clk2,
    output logic strobe,
    output logic w_locked
);
    localparam int CW = $clog2(DIV);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [CW-1:0] div_cnt, div_nxt;
    logic [LW-1:0] lock_cnt, lock_nxt;

    always_comb begin
        strobe   = div_cnt == CW'(DIV - 1);
        div_nxt  = strobe ? '0 : div_cnt + 1'b1;
        lock_nxt = (strobe && lock_cnt != LW'(LOCK_CYCLES)) ? lock_cnt + 1'b1 : lock_cnt;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            div_cnt  <= '0;
            lock_cnt <= '0;
            w_clk2   <= 1'b0;
            w_locked <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            lock_cnt <= lock_nxt;
            w_clk2   <= div_nxt < CW'(DIV / 2);
            w_locked <= w_locked | (lock_nxt == LW'(LOCK_CYCLES));
        end
    end
endmodule

// File: rtl/clk_wiz.sv
// clk_wiz: divided clock with lock indication and a debug probe captured on each rising w_clk2.
module clk_wiz
    import clk_wiz_pkg::*;
#(
    parameter int DIV         = DIV_DEF,
    parameter int LOCK_CYCLES = LOCK_DEF,
    parameter int PW          = PW_DEF
) (
    input logic      w_clk,
    input logic      w_rst,
    clk_wiz_if.slave bus
);
    logic strobe, cap;

    clk_div_lock #(.DIV(DIV), .LOCK_CYCLES(LOCK_CYCLES)) u_div (
        .w_clk    (w_clk),
        .w_rst    (w_rst),
        .w_clk2   (bus.w_clk2),
        .strobe   (strobe),
        .w_locked (bus.w_locked)
    );

    // captures only start on the strobe after lock was already registered
    assign cap = strobe & bus.w_locked;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            bus.w_probe_q    <= '0;
            bus.w_probe_chg  <= 1'b0;
            bus.w_sample_cnt <= '0;
        end else begin
            if (cap) begin
                bus.w_probe_q    <= bus.w_probe_in;
                bus.w_sample_cnt <= sat_inc(bus.w_sample_cnt);
            end
            bus.w_probe_chg <= (cap && bus.w_probe_in != bus.w_probe_q) | (bus.w_probe_chg & ~bus.w_chg_clr);
        end
    end
endmodule

// File: tb/tb_clk_wiz.sv
// tb_clk_wiz: directed checks of clk_wiz with DIV=2/LOCK=16 and DIV=4/LOCK=3 instances side by side.
module tb_clk_wiz;
    import clk_wiz_pkg::*;

    logic w_clk = 1'b0;
    logic w_rst = 1'b0;
    int tests = 0;
    int fails = 0;

    clk_wiz_if #(.PW(32)) b2 ();
    clk_wiz_if #(.PW(32)) b4 ();

    clk_wiz #(.DIV(2), .LOCK_CYCLES(16), .PW(32)) dut2 (.w_clk(w_clk), .w_rst(w_rst), .bus(b2.slave));
    clk_wiz #(.DIV(4), .LOCK_CYCLES(3), .PW(32)) dut4 (.w_clk(w_clk), .w_rst(w_rst), .bus(b4.slave));

    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] v, input logic c);
        b2.w_probe_in = v;
        b4.w_probe_in = v;
        b2.w_chg_clr  = c;
        b4.w_chg_clr  = c;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_d2_clk2"}, b2.w_clk2, 1'b0);
        chk1({tag, "_d2_lock"}, b2.w_locked, 1'b0);
        chk({tag, "_d2_q"}, b2.w_probe_q, 32'h0);
        chk1({tag, "_d2_chg"}, b2.w_probe_chg, 1'b0);
        chk({tag, "_d2_cnt"}, 32'(b2.w_sample_cnt), 32'h0);
        chk1({tag, "_d4_clk2"}, b4.w_clk2, 1'b0);
        chk1({tag, "_d4_lock"}, b4.w_locked, 1'b0);
        chk({tag, "_d4_q"}, b4.w_probe_q, 32'h0);
        chk1({tag, "_d4_chg"}, b4.w_probe_chg, 1'b0);
        chk({tag, "_d4_cnt"}, 32'(b4.w_sample_cnt), 32'h0);
    endtask

    initial begin
        drive(32'h0, 1'b0);
        #1 w_rst = 1'b1;
        #1 chk_zero("por");
        repeat (3) step();
        chk_zero("rst_held");
        @(negedge w_clk);
        w_rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            chk1($sformatf("d2_clk2_e%0d", n), b2.w_clk2, (n % 2) < 1);
            chk1($sformatf("d4_clk2_e%0d", n), b4.w_clk2, (n % 4) < 2);
            chk1($sformatf("d2_lock_e%0d", n), b2.w_locked, n >= 32);
            chk1($sformatf("d4_lock_e%0d", n), b4.w_locked, n >= 12);
        end
        chk("d2_cnt_e40", 32'(b2.w_sample_cnt), 32'd4);
        chk("d4_cnt_e40", 32'(b4.w_sample_cnt), 32'd7);
        chk1("d2_chg_e40", b2.w_probe_chg, 1'b0);
        chk1("d4_chg_e40", b4.w_probe_chg, 1'b0);
        drive(32'hAA, 1'b0);
        step();
        chk("d2_q_e41", b2.w_probe_q, 32'h0);
        chk("d2_cnt_e41", 32'(b2.w_sample_cnt), 32'd4);
        step();
        chk("d2_q_e42", b2.w_probe_q, 32'hAA);
        chk1("d2_chg_e42", b2.w_probe_chg, 1'b1);
        chk("d2_cnt_e42", 32'(b2.w_sample_cnt), 32'd5);
        drive(32'hAA, 1'b1);
        step();
        chk1("d2_chg_clr_e43", b2.w_probe_chg, 1'b0);
        chk("d2_q_e43", b2.w_probe_q, 32'hAA);
        drive(32'hAA, 1'b0);
        step();
        chk1("d2_chg_same_e44", b2.w_probe_chg, 1'b0);
        chk("d2_cnt_e44", 32'(b2.w_sample_cnt), 32'd6);
        chk("d4_q_e44", b4.w_probe_q, 32'hAA);
        chk1("d4_chg_e44", b4.w_probe_chg, 1'b1);
        chk("d4_cnt_e44", 32'(b4.w_sample_cnt), 32'd8);
        drive(32'h55, 1'b1);
        step();
        chk("d2_q_e45", b2.w_probe_q, 32'hAA);
        chk1("d4_chg_clr_e45", b4.w_probe_chg, 1'b0);
        step();
        chk1("d2_chg_setwins_e46", b2.w_probe_chg, 1'b1);
        chk("d2_q_e46", b2.w_probe_q, 32'h55);
        chk("d2_cnt_e46", 32'(b2.w_sample_cnt), 32'd7);
        chk("d4_q_e46", b4.w_probe_q, 32'hAA);
        drive(32'h33, 1'b0);
        step();
        chk("d2_q_between_e47", b2.w_probe_q, 32'h55);
        drive(32'h55, 1'b0);
        step();
        chk("d2_q_e48", b2.w_probe_q, 32'h55);
        chk1("d2_chg_e48", b2.w_probe_chg, 1'b1);
        chk("d2_cnt_e48", 32'(b2.w_sample_cnt), 32'd8);
        chk("d4_q_e48", b4.w_probe_q, 32'h55);
        chk1("d4_chg_e48", b4.w_probe_chg, 1'b1);
        chk("d4_cnt_e48", 32'(b4.w_sample_cnt), 32'd9);
        drive(32'h55, 1'b1);
        step();
        chk1("d2_chg_clr_e49", b2.w_probe_chg, 1'b0);
        chk1("d4_chg_clr_e49", b4.w_probe_chg, 1'b0);
        drive(32'h55, 1'b0);
        #2 w_rst = 1'b1;
        #1 chk_zero("async_rst");
        repeat (2) step();
        @(negedge w_clk);
        w_rst = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            step();
            chk1($sformatf("re_d4_clk2_e%0d", n), b4.w_clk2, (n % 4) < 2);
            chk1($sformatf("re_d2_lock_e%0d", n), b2.w_locked, n >= 32);
            chk1($sformatf("re_d4_lock_e%0d", n), b4.w_locked, n >= 12);
            chk($sformatf("re_d2_cnt_e%0d", n), 32'(b2.w_sample_cnt), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
